// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg: shared constants, pointer sizing helper and pointer type for the frame FIFO.
package axis_fifo_pkg;
  localparam int BAD_FRAME_BIT = 0;
  localparam int DEFAULT_DEPTH = 64;
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction
  typedef logic [addr_width(DEFAULT_DEPTH):0] ptr_t;
endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: simple dual-port RAM, synchronous write, combinational read.
module axis_fifo_ram
  import axis_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = 9,
  parameter int AW = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/axis_frame_fifo_out.sv
// axis_frame_fifo_out: store-and-forward AXI-stream frame FIFO dropping bad/overflowed frames.
// Optional status pulses enabled by AXIS_FRAME_FIFO_STATUS_EN.
module axis_frame_fifo_out
  import axis_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter bit DROP_BAD_FRAME = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_tdata,
  input  logic                  input_tvalid,
  output logic                  input_tready,
  input  logic                  input_tlast,
  input  logic [USER_WIDTH-1:0] input_tuser,
  output logic [DATA_WIDTH-1:0] output_tdata,
  output logic                  output_tvalid,
  input  logic                  output_tready,
  output logic                  output_tlast
`ifdef AXIS_FRAME_FIFO_STATUS_EN
  ,
  output logic                  status_overflow,
  output logic                  status_bad_frame,
  output logic                  status_good_frame
`endif
);
  localparam int ADDR_WIDTH = addr_width(DEPTH);
  typedef logic [ADDR_WIDTH:0] wptr_t;
  localparam wptr_t FULL_CNT = wptr_t'(DEPTH);
  wptr_t wr_ptr_cur, wr_ptr, rd_ptr, wr_ptr_nxt;
  logic drop_frame, accept, full, empty, wr_en, rd_en, bad_flag, ovf_end, bad_end, good_end;
  logic [DATA_WIDTH:0] rd_word;
  assign input_tready = ~rst;
  always_comb begin
    wr_ptr_nxt = wr_ptr_cur + 1'b1;
    accept = input_tvalid & input_tready;
    full = wptr_t'(wr_ptr_cur - rd_ptr) == FULL_CNT;
    empty = rd_ptr == wr_ptr;
    wr_en = accept & ~drop_frame & ~full;
    bad_flag = DROP_BAD_FRAME & input_tuser[BAD_FRAME_BIT];
    ovf_end = accept & input_tlast & (drop_frame | full);
    bad_end = wr_en & input_tlast & bad_flag;
    good_end = wr_en & input_tlast & ~bad_flag;
    rd_en = ~empty & (~output_tvalid | output_tready);
  end
  axis_fifo_ram #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH + 1)) ram (
    .clk(clk),
    .we(wr_en),
    .waddr(wr_ptr_cur[ADDR_WIDTH-1:0]),
    .wdata({input_tlast, input_tdata}),
    .raddr(rd_ptr[ADDR_WIDTH-1:0]),
    .rdata(rd_word)
  );
  // Any overflow or bad tlast rewinds the speculative pointer; only good tlast commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_cur <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_frame <= 1'b0;
      output_tvalid <= 1'b0;
      output_tlast <= 1'b0;
      output_tdata <= '0;
    end else begin
      if (accept) begin
        drop_frame <= ~input_tlast & (drop_frame | full);
        wr_ptr_cur <= (drop_frame | full | bad_end) ? wr_ptr : wr_ptr_nxt;
      end
      if (good_end) wr_ptr <= wr_ptr_nxt;
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
        output_tvalid <= 1'b1;
        {output_tlast, output_tdata} <= rd_word;
      end else if (output_tready) begin
        output_tvalid <= 1'b0;
      end
    end
  end
`ifdef AXIS_FRAME_FIFO_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      status_overflow <= 1'b0;
      status_bad_frame <= 1'b0;
      status_good_frame <= 1'b0;
    end else begin
      status_overflow <= ovf_end;
      status_bad_frame <= bad_end;
      status_good_frame <= good_end;
    end
  end
`endif
endmodule

// File: tb/tb_axis_frame_fifo_out.sv
// tb_axis_frame_fifo_out: directed table-driven bench for axis_frame_fifo_out.
module tb_axis_frame_fifo_out;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] input_tdata = '0, output_tdata;
  logic input_tvalid = 1'b0, input_tlast = 1'b0, input_tready;
  logic [0:0] input_tuser = '0;
  logic output_tvalid, output_tlast, output_tready = 1'b0;
  int checks = 0, errors = 0;
`ifdef AXIS_FRAME_FIFO_STATUS_EN
  logic status_overflow, status_bad_frame, status_good_frame;
`endif
  axis_frame_fifo_out dut (
    .clk(clk),
    .rst(rst),
    .input_tdata(input_tdata),
    .input_tvalid(input_tvalid),
    .input_tready(input_tready),
    .input_tlast(input_tlast),
    .input_tuser(input_tuser),
    .output_tdata(output_tdata),
    .output_tvalid(output_tvalid),
    .output_tready(output_tready),
    .output_tlast(output_tlast)
`ifdef AXIS_FRAME_FIFO_STATUS_EN
    ,
    .status_overflow(status_overflow),
    .status_bad_frame(status_bad_frame),
    .status_good_frame(status_good_frame)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] d;
    logic v, l, u, r;
    logic ev;
    logic [7:0] ed;
    logic el;
    logic [2:0] es;
  } vec_t;
  vec_t tv[$];
  task automatic add(input logic [7:0] d, input logic v, l, u, r, ev, input logic [7:0] ed, input logic el, input logic [2:0] es);
    vec_t x;
    x.d = d; x.v = v; x.l = l; x.u = u; x.r = r; x.ev = ev; x.ed = ed; x.el = el; x.es = es;
    tv.push_back(x);
  endtask
  task automatic step(input logic [7:0] d, input logic v, l, u, r);
    @(negedge clk);
    input_tdata = d; input_tvalid = v; input_tlast = l; input_tuser = u; output_tready = r;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic chk_status(input string n, input logic [2:0] exp);
`ifdef AXIS_FRAME_FIFO_STATUS_EN
    chk(n, {status_overflow, status_bad_frame, status_good_frame}, exp);
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int n;
    logic seen;
    // good frame
    add(8'hA1,1,0,0,1, 0,8'h00,0,3'b000);
    add(8'hA2,1,0,0,1, 0,8'h00,0,3'b000);
    add(8'hA3,1,1,0,1, 0,8'h00,0,3'b001);
    add(8'h00,0,0,0,1, 1,8'hA1,0,3'b000);
    add(8'h00,0,0,0,1, 1,8'hA2,0,3'b000);
    add(8'h00,0,0,0,1, 1,8'hA3,1,3'b000);
    add(8'h00,0,0,0,1, 0,8'h00,0,3'b000);
    // bad frame then good frame
    add(8'hB0,1,0,0,1, 0,8'h00,0,3'b000);
    add(8'hB1,1,0,0,1, 0,8'h00,0,3'b000);
    add(8'hB2,1,0,0,1, 0,8'h00,0,3'b000);
    add(8'hB3,1,1,1,1, 0,8'h00,0,3'b010);
    add(8'h10,1,0,0,1, 0,8'h00,0,3'b000);
    add(8'h11,1,1,0,1, 0,8'h00,0,3'b001);
    add(8'h00,0,0,0,1, 1,8'h10,0,3'b000);
    add(8'h00,0,0,0,1, 1,8'h11,1,3'b000);
    add(8'h00,0,0,0,1, 0,8'h00,0,3'b000);
    // back-pressure 1,0,0,1 while draining
    add(8'h01,1,0,0,1, 0,8'h00,0,3'b000);
    add(8'h02,1,0,0,1, 0,8'h00,0,3'b000);
    add(8'h03,1,0,0,1, 0,8'h00,0,3'b000);
    add(8'h04,1,0,0,1, 0,8'h00,0,3'b000);
    add(8'h05,1,1,0,1, 0,8'h00,0,3'b001);
    add(8'h00,0,0,0,1, 1,8'h01,0,3'b000);
    add(8'h00,0,0,0,1, 1,8'h02,0,3'b000);
    add(8'h00,0,0,0,0, 1,8'h02,0,3'b000);
    add(8'h00,0,0,0,0, 1,8'h02,0,3'b000);
    add(8'h00,0,0,0,1, 1,8'h03,0,3'b000);
    add(8'h00,0,0,0,1, 1,8'h04,0,3'b000);
    add(8'h00,0,0,0,1, 1,8'h05,1,3'b000);
    add(8'h00,0,0,0,1, 0,8'h00,0,3'b000);
    step(0,0,0,0,0);
    step(0,0,0,0,0);
    chk("reset tvalid", output_tvalid, 0);
    chk("reset tdata", output_tdata, 0);
    chk("reset tlast", output_tlast, 0);
    chk("reset tready", input_tready, 0);
    chk_status("reset status", 3'b000);
    rst = 1'b0;
    step(0,0,0,0,1);
    chk("run tready", input_tready, 1);
    foreach (tv[i]) begin
      step(tv[i].d, tv[i].v, tv[i].l, tv[i].u, tv[i].r);
      chk($sformatf("vec%0d valid", i), output_tvalid, tv[i].ev);
      if (tv[i].ev) begin
        chk($sformatf("vec%0d data", i), output_tdata, tv[i].ed);
        chk($sformatf("vec%0d last", i), output_tlast, tv[i].el);
      end
      chk_status($sformatf("vec%0d status", i), tv[i].es);
    end
    // overflow: 60-beat frame fits, following 10-beat frame does not
    for (int i = 0; i < 60; i++) step(8'(i), 1, i == 59, 0, 0);
    chk_status("ovf first commit", 3'b001);
    for (int j = 0; j < 10; j++) step(8'(8'h80 + j), 1, j == 9, 0, 0);
    chk_status("ovf dropped", 3'b100);
    chk("ovf held valid", output_tvalid, 1);
    chk("ovf held data", output_tdata, 0);
    n = 0;
    for (int c = 0; c < 80; c++) begin
      if (output_tvalid) begin
        if (n < 60) begin
          chk($sformatf("ovf beat%0d data", n), output_tdata, n);
          chk($sformatf("ovf beat%0d last", n), output_tlast, n == 59);
        end
        n++;
      end
      step(0,0,0,0,1);
    end
    chk("ovf beat count", n, 60);
    // oversize frame
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step(8'(i), 1, i == 69, 0, 1);
      seen |= output_tvalid;
    end
    chk_status("oversize dropped", 3'b100);
    chk("oversize quiet", seen, 0);
    step(8'h55,1,1,0,1);
    chk("post-oversize commit valid", output_tvalid, 0);
    step(0,0,0,0,1);
    chk("post-oversize valid", output_tvalid, 1);
    chk("post-oversize data", output_tdata, 8'h55);
    chk("post-oversize last", output_tlast, 1);
    step(0,0,0,0,1);
    chk("post-oversize idle", output_tvalid, 0);
    // reset mid-frame with a stalled output beat pending
    step(8'h99,1,1,0,0);
    step(8'hE1,1,0,0,0);
    step(8'hE2,1,0,0,0);
    chk("pre-reset valid", output_tvalid, 1);
    rst = 1'b1;
    step(0,0,0,0,0);
    chk("mid reset valid", output_tvalid, 0);
    chk("mid reset tready", input_tready, 0);
    chk("mid reset wr_ptr_cur", dut.wr_ptr_cur, 0);
    chk("mid reset wr_ptr", dut.wr_ptr, 0);
    chk("mid reset rd_ptr", dut.rd_ptr, 0);
    rst = 1'b0;
    step(8'h77,1,1,0,1);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      step(0,0,0,0,1);
      if (output_tvalid) begin
        chk("post-reset data", output_tdata, 8'h77);
        chk("post-reset last", output_tlast, 1);
        n++;
      end
    end
    chk("post-reset beat count", n, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_frame_fifo_out.md
Name: axis_frame_fifo_out

Overview:
- Store-and-forward frame FIFO that sits directly downstream of the 4-input AXI-stream arbiter and consumes its output_* stream.
- A frame is released to the next stage only once its final beat (tlast) has been written.
- Frames marked bad (tuser[0]=1 on tlast) or frames that overflow the buffer are discarded whole.
- Output side never sees a partial or bad frame.

Parameters:
- DEPTH, 64, storage depth in beats; must be a power of 2, at least 4.
- DATA_WIDTH, 8, tdata width; matches the arbiter.
- USER_WIDTH, 1, tuser width; only bit 0 is interpreted.
- DROP_BAD_FRAME, 1, 1: discard a frame whose tlast beat carries tuser[0]=1; 0: commit it like a good frame.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- input_tdata  in  DATA_WIDTH  beat data from the arbiter output.
- input_tvalid  in  1  beat valid.
- input_tready  out  1  constant 1 outside reset; FIFO drops rather than back-pressures.
- input_tlast  in  1  last beat of frame.
- input_tuser  in  USER_WIDTH  bit 0 = bad-frame flag, sampled only on the tlast beat.
- output_tdata  out  DATA_WIDTH  registered output data.
- output_tvalid  out  1  registered output valid.
- output_tready  in  1  downstream ready.
- output_tlast  out  1  registered output last.

Behaviour:
- Pointers: ADDR_WIDTH = log2(DEPTH). Three pointers, each ADDR_WIDTH+1 bits with an extra wrap bit:
  - wr_ptr_cur: speculative write pointer.
  - wr_ptr: committed write pointer.
  - rd_ptr: read pointer.
- full = (wr_ptr_cur - rd_ptr) == DEPTH, using modular (ADDR_WIDTH+1)-bit subtraction. empty = (rd_ptr == wr_ptr).
- Beat accept: input_tvalid & input_tready.
- Write, not dropping and not full: store the beat at wr_ptr_cur[ADDR_WIDTH-1:0]; wr_ptr_cur++.
- Write when full, and not already dropping: set drop_frame; wr_ptr_cur <= wr_ptr. The beat is discarded.
- While drop_frame=1: discard every accepted beat. On the tlast beat, clear drop_frame.
- Commit, on the tlast beat with drop_frame=0 and no overflow on that beat:
  - If DROP_BAD_FRAME and input_tuser[0]: wr_ptr_cur <= wr_ptr (frame discarded).
  - Else: wr_ptr <= wr_ptr_cur+1. The tlast beat is written in the same cycle.
- Overflow on the tlast beat itself: whole frame dropped; drop_frame stays 0 afterwards.
- Frame longer than DEPTH beats: always overflows, so it is always dropped; the FIFO recovers at that frame's tlast.
- Read: when !empty and (!output_tvalid | output_tready):
  - load output_tdata/output_tlast from mem[rd_ptr];
  - output_tvalid <= 1;
  - rd_ptr++.
- Output clear: when empty and output_tready, output_tvalid <= 0.
- Latency: tlast accepted at edge N commits wr_ptr at N; first beat of that frame has output_tvalid=1 after edge N+1 if the output register is free. Throughput is 1 beat/cycle in steady state.
- Simultaneous commit and read in one cycle are legal and independent. Read uses the committed wr_ptr only.
- Output holds tdata/tlast stable while output_tvalid & !output_tready.
- Reset, synchronous, dominates all other activity:
  - wr_ptr_cur = wr_ptr = rd_ptr = 0, drop_frame = 0;
  - output_tvalid = 0, output_tlast = 0, output_tdata = 0;
  - input_tready = 0 during rst;
  - any partial or queued frame is lost.

Optional Feature:
- Macro: AXIS_FRAME_FIFO_STATUS_EN.
- Defined: adds three 1-cycle output pulses, all 0 in reset, valid the cycle after the relevant tlast edge:
  - status_overflow: frame dropped because the FIFO was full;
  - status_bad_frame: frame dropped because of tuser;
  - status_good_frame: frame committed.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package axis_fifo_pkg:
  - ADDR_WIDTH computation function (clog2 wrapper);
  - ptr_t typedef sized ADDR_WIDTH+1;
  - localparam BAD_FRAME_BIT = 0.
- Sub-module axis_fifo_ram: simple dual-port RAM with synchronous write, combinational read index, DEPTH x (DATA_WIDTH+1) storing {tlast, tdata}. All pointer and FSM logic stays in the top.

Test Plan:
- Good frame: 3-beat frame 0xA1,0xA2,0xA3, tuser=0, output_tready=1 -> output_tvalid rises 1 edge after the tlast edge; 0xA1,0xA2,0xA3 on consecutive cycles, tlast only on 0xA3.
- Bad frame: 4-beat frame with tuser[0]=1 on tlast, DROP_BAD_FRAME=1 -> no output beats; a following good 2-beat frame 0x10,0x11 appears intact. With the macro defined, status_bad_frame pulses once.
- Overflow: DEPTH=64, output_tready=0, write a 60-beat good frame then a 10-beat frame -> second frame dropped (status_overflow=1); release output_tready -> exactly 60 beats out, ending with tlast.
- Oversize frame: DEPTH=64, output_tready=1, 70-beat frame then 1-beat frame 0x55 -> only 0x55 emerged, with tlast=1.
- Back-pressure: toggle output_tready 1,0,0,1 during a 5-beat frame 0x01..0x05 -> tdata held stable while stalled; no beat lost or duplicated.
- Reset mid-frame: rst=1 for 1 cycle after beat 2 of a 4-beat frame -> output_tvalid=0 the next cycle; pointers equal 0; the next 1-beat frame 0x77 is the only output.
